// File: rtl/sayeh_memory_responder.sv
// SAYEH bus memory responder: word RAM behind a ReadMem/WriteMem level handshake with WAIT_STATES wait cycles.
// Optional build macro MEM_WRITE_PROTECT_EN: words below PROTECT_LIMIT are read-only and dropped writes pulse WriteFault.
module sayeh_memory_responder #(
  parameter int ADDR_BITS     = 10,
  parameter int WAIT_STATES   = 2,
  parameter int PROTECT_LIMIT = 64
) (
  input  logic        clk,
  input  logic        ExternalReset,
  input  logic [15:0] Addressbus,
  inout  wire  [15:0] Databus,
  input  logic        ReadMem,
  input  logic        WriteMem,
  output logic        MemDataReady,
`ifdef MEM_WRITE_PROTECT_EN
  output logic        WriteFault,
`endif
  output logic [1:0]  dbg_state_o
);

  // Handshake: the requester raises ReadMem or WriteMem (level) and holds it, with write data
  // stable on Databus, until it sees MemDataReady; dropping the strobe earlier aborts the access,
  // dropping it while MemDataReady is high completes it and frees the bus on the next edge.

  localparam int DEPTH = 1 << ADDR_BITS;

`ifdef MEM_WRITE_PROTECT_EN
  localparam bit PROTECT_EN = 1'b1;
`else
  localparam bit PROTECT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rdata_q, rdata_d;
  logic        op_rd_q, op_rd_d;

  logic [15:0] mem_q [DEPTH];

  logic req;
  logic strobe;
  logic in_range;
  logic protect_hit;
  logic commit;
  logic mem_we;
  logic drive_en;

  assign req    = ReadMem | WriteMem;
  // Only the strobe of the captured operation keeps the access alive.
  assign strobe = op_rd_q ? ReadMem : WriteMem;

  assign in_range    = (addr_q >> ADDR_BITS) == 16'd0;
  assign protect_hit = PROTECT_EN && (addr_q < 16'(PROTECT_LIMIT));

  // Access happens on the WAIT->DONE edge; a reset on that edge wins and nothing is committed.
  assign commit = (state_q == ST_WAIT) && (state_d == ST_DONE) && !ExternalReset;
  assign mem_we = commit && !op_rd_q && in_range && !protect_hit;

  always_ff @(posedge clk) begin
    if (ExternalReset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!strobe) begin
          state_d = ST_IDLE;
        end else if (cnt_q == 4'd0) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (!strobe) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    MemDataReady = (state_q == ST_DONE);
    drive_en     = (state_q == ST_DONE) && op_rd_q && ReadMem;
  end

  assign Databus     = drive_en ? rdata_q : 16'hzzzz;
  assign dbg_state_o = state_q;

  always_comb begin
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    op_rd_d = op_rd_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    if ((state_q == ST_IDLE) && req) begin
      cnt_d   = 4'(WAIT_STATES);
      addr_d  = Addressbus;
      op_rd_d = ReadMem;
      wdata_d = Databus;
    end else if ((state_q == ST_WAIT) && (cnt_q != 4'd0)) begin
      cnt_d = cnt_q - 4'd1;
    end
    if (commit && op_rd_q) begin
      rdata_d = in_range ? mem_q[addr_q[ADDR_BITS-1:0]] : 16'h0000;
    end
  end

  always_ff @(posedge clk) begin
    if (ExternalReset) begin
      cnt_q   <= 4'd0;
      addr_q  <= 16'h0000;
      op_rd_q <= 1'b0;
      wdata_q <= 16'h0000;
      rdata_q <= 16'h0000;
    end else begin
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      op_rd_q <= op_rd_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[addr_q[ADDR_BITS-1:0]] <= wdata_q;
    end
  end

`ifdef MEM_WRITE_PROTECT_EN
  logic fault_q;

  always_ff @(posedge clk) begin
    if (ExternalReset) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= commit && !op_rd_q && in_range && protect_hit;
    end
  end

  assign WriteFault = fault_q;
`endif

endmodule

// File: tb/tb_sayeh_memory_responder.sv
// Bench for sayeh_memory_responder: directed and random accesses, scoreboard queue checked by a negedge monitor.
// Build with MEM_WRITE_PROTECT_EN defined to exercise write protection.
module tb_sayeh_memory_responder;
  localparam int AB = 10;
  localparam int WS = 2;
  localparam int PL = 64;
  localparam int W  = 19;  // {fault, is_read, data_known, data[15:0]}

`ifdef MEM_WRITE_PROTECT_EN
  localparam bit PROT = 1'b1;
`else
  localparam bit PROT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        ExternalReset;
  logic [15:0] Addressbus;
  wire  [15:0] Databus;
  logic        ReadMem;
  logic        WriteMem;
  logic        MemDataReady;
  logic [1:0]  dbg_state;
`ifdef MEM_WRITE_PROTECT_EN
  logic        WriteFault;
`endif
  logic        tb_drive;
  logic [15:0] tb_data;

  assign Databus = tb_drive ? tb_data : 16'hzzzz;

  int checks   = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];
  logic [15:0]  model_mem [int];
  logic [W-1:0] cur_exp = '0;
  logic         prev_rdy = 1'b0;
  bit           mon_en = 1'b0;

  sayeh_memory_responder #(
    .ADDR_BITS    (AB),
    .WAIT_STATES  (WS),
    .PROTECT_LIMIT(PL)
  ) dut (
    .clk          (clk),
    .ExternalReset(ExternalReset),
    .Addressbus   (Addressbus),
    .Databus      (Databus),
    .ReadMem      (ReadMem),
    .WriteMem     (WriteMem),
    .MemDataReady (MemDataReady),
`ifdef MEM_WRITE_PROTECT_EN
    .WriteFault   (WriteFault),
`endif
    .dbg_state_o  (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Undriven bus reads as Z in 4-state simulators and as 0 in 2-state ones.
  task automatic chk_idle(input string name);
    checks++;
    if (!(Databus === 16'hzzzz || Databus === 16'h0000)) begin
      failures++;
      $display("FAIL %s actual=%h required=zzzz", name, Databus);
    end
  endtask

  // Reference model: memory as a sparse map, applied at issue time in request order.
  function automatic logic [W-1:0] model_access(input logic [15:0] a, input logic [15:0] d,
                                                input bit rd);
    logic [W-1:0] e;
    bit inr;
    bit prot;
    e    = '0;
    inr  = int'(a) < (1 << AB);
    prot = PROT && (int'(a) < PL);
    if (rd) begin
      e[17] = 1'b1;
      if (!inr) begin
        e[16]   = 1'b1;
        e[15:0] = 16'h0000;
      end else if (model_mem.exists(int'(a))) begin
        e[16]   = 1'b1;
        e[15:0] = model_mem[int'(a)];
      end
    end else begin
      if (inr && !prot) model_mem[int'(a)] = d;
      e[18] = inr && prot;
    end
    return e;
  endfunction

  // driver tasks: all start and end just after a rising edge
  task automatic access(input logic [15:0] a, input logic [15:0] d, input bit rd, input bit wr);
    int cyc;
    bit seen;
    int hold;
    cyc  = 0;
    seen = 1'b0;
    exp_q.push_back(model_access(a, d, rd));
    Addressbus = a;
    ReadMem    = rd;
    WriteMem   = wr;
    tb_data    = d;
    tb_drive   = wr && !rd;
    while (!seen && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      seen = MemDataReady;
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout actual=%0d cycles required=%0d", cyc, WS + 2);
      if (exp_q.size() > 0) void'(exp_q.pop_back());
    end else begin
      chk("latency", cyc, WS + 2);
    end
    hold = $urandom_range(1, 2);
    repeat (hold) begin
      @(posedge clk); #1;
    end
    ReadMem  = 1'b0;
    WriteMem = 1'b0;
    tb_drive = 1'b0;
    @(posedge clk); #1;
    chk("ready_drop", MemDataReady, 1'b0);
  endtask

  task automatic abort_access(input logic [15:0] a, input logic [15:0] d, input bit rd,
                              input int hold);
    Addressbus = a;
    ReadMem    = rd;
    WriteMem   = !rd;
    tb_data    = d;
    tb_drive   = !rd;
    repeat (hold) begin
      @(posedge clk); #1;
    end
    ReadMem  = 1'b0;
    WriteMem = 1'b0;
    tb_drive = 1'b0;
    repeat (WS + 3) begin
      @(posedge clk); #1;
      chk("abort_no_ready", MemDataReady, 1'b0);
    end
    chk("abort_state_idle", dbg_state, 2'd0);
  endtask

  // Reset lands exactly on the edge that would have committed the write.
  task automatic reset_during_write(input logic [15:0] a, input logic [15:0] d);
    Addressbus = a;
    WriteMem   = 1'b1;
    ReadMem    = 1'b0;
    tb_data    = d;
    tb_drive   = 1'b1;
    repeat (WS + 1) begin
      @(posedge clk); #1;
    end
    ExternalReset = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_ready", MemDataReady, 1'b0);
    chk("rst_mid_state", dbg_state, 2'd0);
    ExternalReset = 1'b0;
    WriteMem      = 1'b0;
    tb_drive      = 1'b0;
    @(posedge clk); #1;
  endtask

  function automatic logic [15:0] rand_addr();
    case ($urandom_range(0, 5))
      0:       return 16'($urandom_range(1 << AB, 16'hFFFF));
      1:       return 16'($urandom_range(0, (1 << AB) - 1));
      default: return 16'($urandom_range(16'h0038, 16'h0047));
    endcase
  endfunction

  // scoreboard monitor
  always @(negedge clk) begin
    logic exp_fault;
    exp_fault = 1'b0;
    if (mon_en) begin
      if (MemDataReady && !prev_rdy) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL spurious_ready actual=1 required=0");
          cur_exp = '0;
        end else begin
          cur_exp   = exp_q.pop_front();
          exp_fault = cur_exp[18];
        end
      end
`ifdef MEM_WRITE_PROTECT_EN
      chk("write_fault", WriteFault, exp_fault);
`endif
      if (MemDataReady && ReadMem && cur_exp[17]) begin
        if (cur_exp[16]) chk("read_data", Databus, cur_exp[15:0]);
      end else if (!tb_drive) begin
        chk_idle("bus_idle");
      end
    end
    prev_rdy = MemDataReady;
  end

  initial begin
    logic [15:0] a;
    logic [15:0] d;
    int k;
    ExternalReset = 1'b1;
    Addressbus    = 16'h0000;
    ReadMem       = 1'b0;
    WriteMem      = 1'b0;
    tb_drive      = 1'b0;
    tb_data       = 16'h0000;
    repeat (2) begin
      @(posedge clk); #1;
    end
    chk("reset_ready", MemDataReady, 1'b0);
    chk("reset_state", dbg_state, 2'd0);
    chk_idle("reset_bus");
    ExternalReset = 1'b0;
    mon_en        = 1'b1;
    @(posedge clk); #1;

    access(16'h0100, 16'hA5C3, 1'b0, 1'b1);
    access(16'h0100, 16'h0000, 1'b1, 1'b0);

    access(16'h0010, 16'h1111, 1'b0, 1'b1);
    abort_access(16'h0010, 16'h2222, 1'b0, 1);
    abort_access(16'h0010, 16'h0000, 1'b1, 1);
    abort_access(16'h0010, 16'h3333, 1'b0, WS + 1);
    access(16'h0010, 16'h0000, 1'b1, 1'b0);

    access(16'h0000, 16'h3C3C, 1'b0, 1'b1);
    access(16'h8000, 16'h0000, 1'b1, 1'b0);
    access(16'h8000, 16'h7777, 1'b0, 1'b1);
    access(16'h0000, 16'h0000, 1'b1, 1'b0);

    access(16'h0020, 16'h0F0F, 1'b0, 1'b1);
    access(16'h0020, 16'hBEEF, 1'b1, 1'b1);
    access(16'h0020, 16'h0000, 1'b1, 1'b0);
    reset_during_write(16'h0020, 16'h5555);
    access(16'h0020, 16'h0000, 1'b1, 1'b0);

    access(16'h0003, 16'hDEAD, 1'b0, 1'b1);
    access(16'h0003, 16'h0000, 1'b1, 1'b0);
    access(16'h0040, 16'hCAFE, 1'b0, 1'b1);
    access(16'h0040, 16'h0000, 1'b1, 1'b0);

    for (int i = 0; i < 16; i++) begin
      access(16'h0038 + 16'(i), 16'h1000 + 16'(i), 1'b0, 1'b1);
    end

    for (int i = 0; i < 150; i++) begin
      a = rand_addr();
      d = 16'($urandom_range(1, 16'hFFFF));
      k = $urandom_range(0, 9);
      if (k <= 5)      access(a, d, k[0], !k[0]);
      else if (k <= 7) abort_access(a, d, k[0], $urandom_range(1, WS + 1));
      else if (k == 8) access(a, d, 1'b1, 1'b1);
      else             access(a, d, 1'b1, 1'b0);
    end

    repeat (3) begin
      @(posedge clk); #1;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL queue_drained actual=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
